// File: rtl/clked_edge_oneshot_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clked_edge_oneshot_multi_if
// Description : Control/status bundle for the multi-channel edge one-shot.
// Revision    : 1.0 - initial release
// ============================================================================
interface clked_edge_oneshot_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   input_pulse;
  logic [2*CHANNELS-1:0] edge_sel;
  logic                  ovr_clr;
  logic [CHANNELS-1:0]   oneshot;
  logic [CHANNELS-1:0]   overrun;
  logic                  any_active;

  modport master (
    output input_pulse,
    output edge_sel,
    output ovr_clr,
    input  oneshot,
    input  overrun,
    input  any_active
  );

  modport slave (
    input  input_pulse,
    input  edge_sel,
    input  ovr_clr,
    output oneshot,
    output overrun,
    output any_active
  );
endinterface
`default_nettype wire

// File: rtl/clked_edge_oneshot_multi.sv
`default_nettype none
// ============================================================================
// Module      : clked_edge_oneshot_multi
// Description : Per-channel synchronised edge detector driving a one-shot pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module clked_edge_oneshot_multi #(
  parameter int CHANNELS    = 4,
  parameter int PULSE_LEN   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RETRIGGER   = 0
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  clked_edge_oneshot_multi_if.slave     bus
);

  localparam int CNT_W     = $clog2(PULSE_LEN + 1);
  localparam int ARM_EDGES = SYNC_STAGES + 1;
  localparam int ARM_W     = $clog2(ARM_EDGES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  logic [CHANNELS-1:0] w_d;
  logic [CHANNELS-1:0] r_prev;
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_pulse_nxt;
  logic [CHANNELS-1:0] w_oneshot;
  logic [CHANNELS-1:0] w_overrun;
  logic [ARM_W-1:0]    r_arm_cnt;
  logic                w_armed;
  logic                r_any_active;

  // Detection stays off until prev has caught up with the synchroniser
  // contents, so a level held through reset never looks like an edge.
  assign w_armed = (r_arm_cnt == ARM_W'(ARM_EDGES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_d = bus.input_pulse;
    end else begin : g_sync
      logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
          end
        end else begin
          r_sync[0] <= bus.input_pulse;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
          end
        end
      end

      assign w_d = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_d;
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i] = w_armed &
                 ((bus.edge_sel[2*i]   & w_d[i] & ~r_prev[i]) |
                  (bus.edge_sel[2*i+1] & ~w_d[i] & r_prev[i]));
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_ovr;
      logic             w_ovr_nxt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_ovr   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_ovr   <= w_ovr_nxt;
        end
      end

      // Clear is applied first so a lost edge on the same clock re-sets the flag.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ovr_nxt   = r_ovr & ~bus.ovr_clr;
        case (r_state)
          ST_IDLE: begin
            if (w_hit[i]) begin
              w_state_nxt = ST_PULSE;
              w_cnt_nxt   = CNT_RELOAD;
            end
          end
          ST_PULSE: begin
            if (r_cnt == '0) begin
              if (w_hit[i]) begin
                w_cnt_nxt = CNT_RELOAD;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end else if (w_hit[i] && (RETRIGGER != 0)) begin
              w_cnt_nxt = CNT_RELOAD;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
              if (w_hit[i]) begin
                w_ovr_nxt = 1'b1;
              end
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end

      assign w_pulse_nxt[i] = (w_state_nxt == ST_PULSE);
      assign w_oneshot[i]   = (r_state == ST_PULSE);
      assign w_overrun[i]   = r_ovr;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_any_active <= 1'b0;
    end else begin
      r_any_active <= |w_pulse_nxt;
    end
  end

  assign bus.oneshot    = w_oneshot;
  assign bus.overrun    = w_overrun;
  assign bus.any_active = r_any_active;

endmodule
`default_nettype wire

// File: tb/tb_clked_edge_oneshot_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clked_edge_oneshot_multi
// Description : Three configurations driven in parallel against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clked_edge_oneshot_multi;

  localparam int CH   = 4;
  localparam int NCFG = 3;

  // cfg0: L=4 S=2 no retrigger; cfg1: L=4 S=2 retrigger; cfg2: L=1 S=0
  function automatic int cfg_len(input int k);
    return (k == 2) ? 1 : 4;
  endfunction
  function automatic int cfg_sync(input int k);
    return (k == 2) ? 0 : 2;
  endfunction
  function automatic bit cfg_retrig(input int k);
    return (k == 1);
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic [CH-1:0]   ip;
  logic [2*CH-1:0] es;
  logic        oc;

  always #5 clk = ~clk;

  clked_edge_oneshot_multi_if #(.CHANNELS(CH)) ifa ();
  clked_edge_oneshot_multi_if #(.CHANNELS(CH)) ifb ();
  clked_edge_oneshot_multi_if #(.CHANNELS(CH)) ifc ();

  assign ifa.input_pulse = ip;
  assign ifa.edge_sel    = es;
  assign ifa.ovr_clr     = oc;
  assign ifb.input_pulse = ip;
  assign ifb.edge_sel    = es;
  assign ifb.ovr_clr     = oc;
  assign ifc.input_pulse = ip;
  assign ifc.edge_sel    = es;
  assign ifc.ovr_clr     = oc;

  clked_edge_oneshot_multi #(.CHANNELS(CH), .PULSE_LEN(4), .SYNC_STAGES(2), .RETRIGGER(0))
    u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  clked_edge_oneshot_multi #(.CHANNELS(CH), .PULSE_LEN(4), .SYNC_STAGES(2), .RETRIGGER(1))
    u_dut_b (.clk(clk), .reset(reset), .bus(ifb));
  clked_edge_oneshot_multi #(.CHANNELS(CH), .PULSE_LEN(1), .SYNC_STAGES(0), .RETRIGGER(0))
    u_dut_c (.clk(clk), .reset(reset), .bus(ifc));

  logic [CH-1:0] dos  [NCFG];
  logic [CH-1:0] dov  [NCFG];
  logic          dany [NCFG];

  always_comb begin
    dos[0] = ifa.oneshot;  dov[0] = ifa.overrun;  dany[0] = ifa.any_active;
    dos[1] = ifb.oneshot;  dov[1] = ifb.overrun;  dany[1] = ifb.any_active;
    dos[2] = ifc.oneshot;  dov[2] = ifc.overrun;  dany[2] = ifc.any_active;
  end

  int checks = 0;
  int errors = 0;

  // Model: raw-input history stands in for the synchroniser; rem counts the
  // high cycles still owed on each channel after the current edge.
  logic [CH-1:0] hist  [4];
  logic [CH-1:0] prevd [NCFG];
  int            rem   [NCFG][CH];
  logic [CH-1:0] eov   [NCFG];
  int            since;
  bit            started = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] d;
    bit armed, rise, fall, hit;
    if (reset) begin
      for (int j = 0; j < 4; j++) hist[j] = '0;
      for (int k = 0; k < NCFG; k++) begin
        prevd[k] = '0;
        eov[k]   = '0;
        for (int c = 0; c < CH; c++) rem[k][c] = 0;
      end
      since   = 0;
      started = 1;
    end else begin
      for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = ip;
      for (int k = 0; k < NCFG; k++) begin
        d     = hist[cfg_sync(k)];
        armed = (since >= cfg_sync(k) + 1);
        for (int c = 0; c < CH; c++) begin
          rise = d[c] && !prevd[k][c];
          fall = !d[c] && prevd[k][c];
          hit  = armed && ((es[2*c] && rise) || (es[2*c+1] && fall));
          if (oc) eov[k][c] = 1'b0;
          if (hit) begin
            if (rem[k][c] <= 1 || cfg_retrig(k)) begin
              rem[k][c] = cfg_len(k);
            end else begin
              rem[k][c] = rem[k][c] - 1;
              eov[k][c] = 1'b1;
            end
          end else if (rem[k][c] > 0) begin
            rem[k][c] = rem[k][c] - 1;
          end
        end
        prevd[k] = d;
      end
      if (since < 100) since++;
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e;
    if (!started) return;
    for (int k = 0; k < NCFG; k++) begin
      for (int c = 0; c < CH; c++) e[c] = (rem[k][c] > 0);
      chk($sformatf("oneshot cfg%0d", k), 8'(dos[k]), 8'(e));
      chk($sformatf("overrun cfg%0d", k), 8'(dov[k]), 8'(eov[k]));
      chk($sformatf("any_active cfg%0d", k), 8'(dany[k]), 8'(|e));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int na, nb;
    reset = 1'b1;
    ip    = '1;
    es    = '1;
    oc    = 1'b0;

    // Level held high through reset must not fire
    repeat (3) cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      for (int k = 0; k < NCFG; k++) begin
        chk($sformatf("post-reset any cfg%0d", k), 8'(dany[k]), 8'h00);
        chk($sformatf("post-reset os cfg%0d", k), 8'(dos[k]), 8'h00);
      end
    end

    // Falling-only on ch0, unsynchronised single-cycle pulse
    es = 8'b00_00_00_10;
    ip[0] = 1'b0; cycle();
    chk("fall pulse cfg2", 8'(dos[2][0]), 8'h01);
    cycle();
    chk("fall pulse end cfg2", 8'(dos[2][0]), 8'h00);
    ip[0] = 1'b1; cycle();
    chk("rise ignored cfg2", 8'(dos[2][0]), 8'h00);
    cycle();
    chk("rise ignored2 cfg2", 8'(dos[2][0]), 8'h00);

    // Two rising hits two edges apart on ch1
    es = 8'b00_00_01_00;
    ip = '0;
    repeat (6) cycle();
    ip[1] = 1'b1; cycle();
    ip[1] = 1'b0; cycle();
    ip[1] = 1'b1;
    na = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      na += int'(dos[0][1]);
      nb += int'(dos[1][1]);
    end
    chk("pulse len no-retrig", 8'(na), 8'd4);
    chk("pulse len retrig", 8'(nb), 8'd6);
    chk("overrun set cfg0", 8'(dov[0][1]), 8'h01);
    chk("overrun clear cfg1", 8'(dov[1][1]), 8'h00);
    oc = 1'b1; cycle(); oc = 1'b0;
    chk("ovr_clr cfg0", 8'(dov[0][1]), 8'h00);
    ip[1] = 1'b0; repeat (4) cycle();
    ip[1] = 1'b1; cycle();
    ip[1] = 1'b0; cycle();
    ip[1] = 1'b1; cycle();
    cycle();
    oc = 1'b1; cycle(); oc = 1'b0;
    chk("set beats clr cfg0", 8'(dov[0][1]), 8'h01);
    chk("no ovr retrig cfg1", 8'(dov[1][1]), 8'h00);

    // Both-edge toggling gives a continuous single-cycle pulse train
    es = 8'b00_11_00_00;
    ip = '0;
    repeat (2) cycle();
    for (int i = 0; i < 8; i++) begin
      ip[2] = ~ip[2]; cycle();
      chk("toggle both cfg2", 8'(dos[2][2]), 8'h01);
    end
    es[5:4] = 2'b00;
    for (int i = 0; i < 8; i++) begin
      ip[2] = ~ip[2]; cycle();
      chk("toggle off cfg2", 8'(dos[2][2]), 8'h00);
    end

    // Reset in the middle of two simultaneous pulses
    es = 8'b01_01_00_00;
    ip = '0;
    repeat (5) cycle();
    ip[3:2] = 2'b11;
    repeat (5) cycle();
    chk("dual pulse cfg0", 8'(dos[0][3:2]), 8'h03);
    reset = 1'b1; cycle();
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("reset os cfg%0d", k), 8'(dos[k]), 8'h00);
      chk($sformatf("reset any cfg%0d", k), 8'(dany[k]), 8'h00);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rearm quiet cfg0", 8'(dany[0]), 8'h00);
    end

    // Randomised traffic, model compared every cycle
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) es = 8'($urandom);
      ip    = ip ^ CH'($urandom & $urandom);
      oc    = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    oc    = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
